// File: rtl/key_event_sched.sv
// Key event sequencer: per-key press timers classify short/long/repeat events, and a
// round-robin arbiter feeds them into a small show-ahead FIFO with a valid/ready drain.
module key_event_sched #(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned LONG_TICKS   = 25_000_000,
  parameter int unsigned REPEAT_TICKS = 5_000_000,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned KW          = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_flag,
  input  logic [N_KEYS-1:0] key_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KW-1:0]     evt_key,
  output logic [1:0]        evt_type,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = KW + 2;

  localparam logic [1:0]  TypShort = 2'b00;
  localparam logic [1:0]  TypLong  = 2'b01;
  localparam logic [1:0]  TypRep   = 2'b10;
  localparam logic [31:0] LongLast = 32'(LONG_TICKS - 1);
  localparam logic [31:0] RepLast  = 32'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {StRel, StPrs, StHld} key_st_e;

  key_st_e           r_st    [N_KEYS];
  key_st_e           w_st_d  [N_KEYS];
  logic [31:0]       r_tmr   [N_KEYS];
  logic [31:0]       w_tmr_d [N_KEYS];
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_rel;
  logic [N_KEYS-1:0] w_raise;
  logic [1:0]        w_rtype [N_KEYS];

  logic [N_KEYS-1:0] r_pend;
  logic [N_KEYS-1:0] w_pend_d;
  logic [1:0]        r_ptype   [N_KEYS];
  logic [1:0]        w_ptype_d [N_KEYS];
  logic [KW-1:0]     r_rr;
  logic [KW-1:0]     w_rr_nxt;
  logic              w_gnt_vld;
  logic [KW-1:0]     w_gnt_idx;
  logic              w_ovf_set;
  logic              r_ovf;

  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     w_rptr_d;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_d;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_push_data;
  logic              r_evt_valid;
  logic [EW-1:0]     r_head;
  logic [EW-1:0]     w_head_d;

  assign w_press = key_flag & ~key_state;
  assign w_rel   = key_flag & key_state;

  // Key FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_st[i]  <= StRel;
        r_tmr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_st[i]  <= w_st_d[i];
        r_tmr[i] <= w_tmr_d[i];
      end
    end
  end

  // Key FSM next state; release always beats a timer terminal count
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      w_st_d[i]  = r_st[i];
      w_tmr_d[i] = (r_tmr[i] == '1) ? r_tmr[i] : r_tmr[i] + 32'd1;
      case (r_st[i])
        StRel: begin
          w_tmr_d[i] = '0;
          if (w_press[i]) w_st_d[i] = StPrs;
        end
        StPrs: begin
          if (w_rel[i]) begin
            w_st_d[i]  = StRel;
            w_tmr_d[i] = '0;
          end else if (r_tmr[i] == LongLast) begin
            w_st_d[i]  = StHld;
            w_tmr_d[i] = '0;
          end
        end
        StHld: begin
          if (w_rel[i]) begin
            w_st_d[i]  = StRel;
            w_tmr_d[i] = '0;
          end else if (r_tmr[i] == RepLast) begin
            w_tmr_d[i] = '0;
          end
        end
        default: begin
          w_st_d[i]  = StRel;
          w_tmr_d[i] = '0;
        end
      endcase
    end
  end

  // Key FSM outputs: event raise and its type
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      w_raise[i] = 1'b0;
      w_rtype[i] = TypShort;
      case (r_st[i])
        StPrs: begin
          if (w_rel[i]) begin
            w_raise[i] = 1'b1;
            w_rtype[i] = TypShort;
          end else if (r_tmr[i] == LongLast) begin
            w_raise[i] = 1'b1;
            w_rtype[i] = TypLong;
          end
        end
        StHld: begin
          if (!w_rel[i] && r_tmr[i] == RepLast) begin
            w_raise[i] = 1'b1;
            w_rtype[i] = TypRep;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin grant: first pending key at or after r_rr, only when the FIFO has room
  always_comb begin
    int unsigned v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!w_full) begin
      for (int unsigned off = 0; off < N_KEYS; off++) begin
        v_idx = (32'(r_rr) + off) % N_KEYS;
        if (!w_gnt_vld && r_pend[v_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = KW'(v_idx);
        end
      end
    end
  end

  assign w_rr_nxt    = (w_gnt_idx == KW'(N_KEYS - 1)) ? '0 : w_gnt_idx + KW'(1);
  assign w_push_data = {w_gnt_idx, r_ptype[w_gnt_idx]};

  // A raise on a pending slot that is not leaving this cycle loses the older event
  always_comb begin
    w_pend_d  = r_pend;
    w_ovf_set = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_ptype_d[i] = r_ptype[i];
      if (w_gnt_vld && w_gnt_idx == KW'(i)) w_pend_d[i] = 1'b0;
      if (w_raise[i]) begin
        if (r_pend[i] && !(w_gnt_vld && w_gnt_idx == KW'(i))) w_ovf_set = 1'b1;
        w_pend_d[i]  = 1'b1;
        w_ptype_d[i] = w_rtype[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_rr   <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) r_ptype[i] <= TypShort;
    end else begin
      r_pend <= w_pend_d;
      for (int i = 0; i < N_KEYS; i++) r_ptype[i] <= w_ptype_d[i];
      if (w_gnt_vld) r_rr <= w_rr_nxt;
      r_ovf <= ovf_clr ? 1'b0 : (r_ovf | w_ovf_set);
    end
  end

  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));
  assign w_push   = w_gnt_vld;
  assign w_pop    = r_evt_valid & evt_ready;
  assign w_cnt_d  = r_cnt + (w_push ? CW'(1) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
  assign w_rptr_d = w_pop ? r_rptr + AW'(1) : r_rptr;

  // Show-ahead head: bypass the write when the new entry becomes the head
  always_comb begin
    w_head_d = r_head;
    if (w_cnt_d != '0 && (w_pop || r_cnt == '0)) begin
      if (w_push && r_wptr == w_rptr_d) w_head_d = w_push_data;
      else                              w_head_d = r_mem[w_rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_evt_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr      <= w_rptr_d;
      r_cnt       <= w_cnt_d;
      r_evt_valid <= (w_cnt_d != '0);
      r_head      <= w_head_d;
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_key   = r_head[EW-1:2];
  assign evt_type  = r_head[1:0];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: short/long/repeat classification, arbitration order,
// FIFO backpressure with overflow, reset mid-hold and a throttled drain.
module tb_key_event_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_flag = 4'h0;
  logic [3:0] key_state = 4'hF;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int q_key[$];
  int q_typ[$];
  int q_cyc[$];

  always #5 clk = ~clk;

  key_event_sched #(
    .N_KEYS      (4),
    .LONG_TICKS  (10),
    .REPEAT_TICKS(4),
    .FIFO_DEPTH  (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Collect every accepted event with the cycle it was taken
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && evt_valid && evt_ready) begin
      q_key.push_back(int'(evt_key));
      q_typ.push_back(int'(evt_type));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic lvl);
    key_flag = mask;
    for (int i = 0; i < 4; i++) if (mask[i]) key_state[i] = lvl;
    tick();
    key_flag = 4'h0;
  endtask

  task automatic clear_q();
    q_key.delete();
    q_typ.delete();
    q_cyc.delete();
  endtask

  task automatic wait_evts(input int n, input int budget);
    int b;
    b = 0;
    while (q_key.size() < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  function automatic int qk(input int i);
    return (i < q_key.size()) ? q_key[i] : -1;
  endfunction

  function automatic int qt(input int i);
    return (i < q_typ.size()) ? q_typ[i] : -1;
  endfunction

  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1000;
  endfunction

  initial begin
    int c0;
    int exp4[6];
    int exp6[8];
    exp4 = '{2, 3, 0, 1, 0, 1};
    exp6 = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state
    tick(2);
    check_eq("rst_valid", evt_valid, 0);
    check_eq("rst_key", evt_key, 0);
    check_eq("rst_type", evt_type, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: short press on key1, exact latency
    clear_q();
    pulse(4'b0010, 1'b0);
    tick(4);
    pulse(4'b0010, 1'b1);
    check_eq("t1_valid_p1", evt_valid, 0);
    tick();
    check_eq("t1_valid_p2", evt_valid, 1);
    check_eq("t1_head_key", evt_key, 1);
    check_eq("t1_head_type", evt_type, 0);
    tick(5);
    check_eq("t1_count", q_key.size(), 1);
    check_eq("t1_key", qk(0), 1);
    check_eq("t1_type", qt(0), 0);
    check_eq("t1_ovf", ovf, 0);

    // 2: key2 long hold with two repeats, nothing on release
    clear_q();
    c0 = cyc;
    pulse(4'b0100, 1'b0);
    tick(19);
    pulse(4'b0100, 1'b1);
    tick(10);
    check_eq("t2_count", q_key.size(), 3);
    check_eq("t2_long_type", qt(0), 1);
    check_eq("t2_rep1_type", qt(1), 2);
    check_eq("t2_rep2_type", qt(2), 2);
    check_eq("t2_keys", (qk(0) == 2 && qk(1) == 2 && qk(2) == 2) ? 1 : 0, 1);
    check_eq("t2_long_time", qc(0) - c0, 12);
    check_eq("t2_rep1_gap", qc(1) - qc(0), 4);
    check_eq("t2_rep2_gap", qc(2) - qc(1), 4);

    // 3: move rr to 2 with a key1 event, then keys 0,1,3 together -> 3,0,1
    clear_q();
    pulse(4'b0010, 1'b0);
    tick(2);
    pulse(4'b0010, 1'b1);
    tick(6);
    check_eq("t3_pre_key", qk(0), 1);
    clear_q();
    pulse(4'b1011, 1'b0);
    tick(3);
    pulse(4'b1011, 1'b1);
    tick(8);
    check_eq("t3_count", q_key.size(), 3);
    check_eq("t3_k0", qk(0), 3);
    check_eq("t3_k1", qk(1), 0);
    check_eq("t3_k2", qk(2), 1);
    check_eq("t3_gap0", qc(1) - qc(0), 1);
    check_eq("t3_gap1", qc(2) - qc(1), 1);

    // 4: backpressure, FIFO full, pending overwrite sets ovf
    clear_q();
    evt_ready = 1'b0;
    pulse(4'hF, 1'b0);
    tick(2);
    pulse(4'hF, 1'b1);
    tick(6);
    check_eq("t4_full_valid", evt_valid, 1);
    check_eq("t4_full_head", evt_key, 2);
    check_eq("t4_none_taken", q_key.size(), 0);
    pulse(4'b0011, 1'b0);
    tick(2);
    pulse(4'b0011, 1'b1);
    tick(3);
    check_eq("t4_ovf_before", ovf, 0);
    pulse(4'b0001, 1'b0);
    tick(2);
    pulse(4'b0001, 1'b1);
    tick(2);
    check_eq("t4_ovf_set", ovf, 1);
    evt_ready = 1'b1;
    wait_evts(6, 40);
    tick(5);
    check_eq("t4_count", q_key.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t4_order%0d", i), qk(i), exp4[i]);
    check_eq("t4_ovf_held", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t4_ovf_clr", ovf, 0);

    // 5: reset while key0 is in the hold/repeat phase
    clear_q();
    evt_ready = 1'b0;
    pulse(4'b0001, 1'b0);
    tick(16);
    check_eq("t5_pre_valid", evt_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", evt_valid, 0);
    check_eq("t5_rst_key", evt_key, 0);
    check_eq("t5_rst_type", evt_type, 0);
    check_eq("t5_rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick(3);
    check_eq("t5_post_valid", evt_valid, 0);
    pulse(4'b0001, 1'b1);
    tick(10);
    check_eq("t5_no_event", q_key.size(), 0);

    // 6: eight events drained with ready toggling every cycle
    clear_q();
    pulse(4'hF, 1'b0);
    tick(2);
    pulse(4'hF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      evt_ready = ~evt_ready;
      tick();
    end
    pulse(4'hF, 1'b0);
    tick(2);
    pulse(4'hF, 1'b1);
    for (int i = 0; i < 30; i++) begin
      evt_ready = ~evt_ready;
      tick();
    end
    evt_ready = 1'b1;
    tick(5);
    check_eq("t6_count", q_key.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t6_key%0d", i), qk(i), exp6[i]);
      check_eq($sformatf("t6_type%0d", i), qt(i), 0);
    end
    check_eq("t6_ovf", ovf, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
